fport_telemetry_tx: RTL

FPort downlink telemetry frame transmitter for the flight controller. It holds one SmartPort-style telemetry value (app ID plus 32-bit data) and waits for the FPort decoder to report a telemetry poll from the receiver. On each poll it serialises one complete byte-stuffed, CRC-protected FPort downlink frame into the existing `uart_tx` byte interface. It is the transmit-side counterpart to the FPort receive/decode path on `RX_IN`.

---
 rtl/fport_telemetry_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fport_telemetry_tx.sv
// FPort downlink telemetry transmitter: holds one SmartPort value and, on each
// receiver poll, streams a byte-stuffed, CRC-protected frame into uart_tx.
module fport_telemetry_tx #(
    parameter int CLKS_PER_BYTE = 400
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        poll,
    input  logic        tel_valid,
    output logic        tel_ready,
    input  logic [15:0] tel_app_id,
    input  logic [31:0] tel_data,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    output logic        frame_busy
);

    localparam int CW = (CLKS_PER_BYTE > 2) ? $clog2(CLKS_PER_BYTE) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(CLKS_PER_BYTE - 2);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    // Handshake: a telemetry value is accepted on any cycle where
    // tel_valid && tel_ready; tel_ready is the registered inverse of pending.
    state_t        state;
    logic          pending;
    logic [15:0]   hold_app;
    logic [31:0]   hold_data;
    logic [7:0]    frm_prim;
    logic [15:0]   frm_app;
    logic [31:0]   frm_data;
    logic [7:0]    sum;
    logic [3:0]    byte_idx;
    logic          stuff_pending;
    logic [7:0]    stuff_byte;
    logic [CW-1:0] gap_cnt;
    logic [7:0]    cur_byte;
    logic          needs_stuff;
    logic          accept;

    assign tel_ready  = ~pending;
    assign frame_busy = (state != IDLE);
    assign accept     = tel_valid & ~pending;

    function automatic logic [7:0] crc_add(input logic [7:0] s, input logic [7:0] b);
        logic [8:0] s9;
        s9 = {1'b0, s} + {1'b0, b};
        return s9[7:0] + {7'b0, s9[8]};
    endfunction

    // byte_idx names the next unstuffed frame byte; index 0 goes out at the poll.
    always_comb begin
        cur_byte = 8'h7E;
        case (byte_idx)
            4'd1:    cur_byte = 8'h08;
            4'd2:    cur_byte = 8'h81;
            4'd3:    cur_byte = frm_prim;
            4'd4:    cur_byte = frm_app[7:0];
            4'd5:    cur_byte = frm_app[15:8];
            4'd6:    cur_byte = frm_data[7:0];
            4'd7:    cur_byte = frm_data[15:8];
            4'd8:    cur_byte = frm_data[23:16];
            4'd9:    cur_byte = frm_data[31:24];
            4'd10:   cur_byte = 8'hFF - sum;
            default: cur_byte = 8'h7E;
        endcase
    end

    assign needs_stuff = (byte_idx inside {[4'd1:4'd10]}) &&
                         (cur_byte == 8'h7E || cur_byte == 8'h7D);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            hold_app  <= '0;
            hold_data <= '0;
        end else if (accept) begin
            // An accept in the poll cycle wins: the snapshot already took the old state.
            pending   <= 1'b1;
            hold_app  <= tel_app_id;
            hold_data <= tel_data;
        end else if (state == IDLE && poll) begin
            pending   <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx_send       <= 1'b0;
            tx_byte       <= 8'h00;
            frm_prim      <= 8'h00;
            frm_app       <= '0;
            frm_data      <= '0;
            sum           <= 8'h00;
            byte_idx      <= 4'd0;
            stuff_pending <= 1'b0;
            stuff_byte    <= 8'h00;
            gap_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_send <= 1'b0;
                    if (poll) begin
                        frm_prim      <= pending ? 8'h10 : 8'h00;
                        frm_app       <= pending ? hold_app : 16'h0000;
                        frm_data      <= pending ? hold_data : 32'h0;
                        sum           <= 8'h00;
                        byte_idx      <= 4'd1;
                        stuff_pending <= 1'b0;
                        tx_byte       <= 8'h7E;
                        tx_send       <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    tx_send <= 1'b0;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else if (stuff_pending) begin
                        tx_byte       <= stuff_byte;
                        stuff_pending <= 1'b0;
                        tx_send       <= 1'b1;
                        state         <= SEND;
                    end else if (byte_idx <= 4'd11) begin
                        if (byte_idx inside {[4'd1:4'd9]})
                            sum <= crc_add(sum, cur_byte);
                        if (needs_stuff) begin
                            tx_byte       <= 8'h7D;
                            stuff_byte    <= cur_byte ^ 8'h20;
                            stuff_pending <= 1'b1;
                        end else begin
                            tx_byte <= cur_byte;
                        end
                        byte_idx <= byte_idx + 4'd1;
                        tx_send  <= 1'b1;
                        state    <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
